// File: rtl/tl_pkg.sv
// Shared lamp encodings and phase codes for the actuated intersection controller.
package tl_pkg;

  localparam int unsigned LAMP_W  = 4;
  localparam int unsigned PHASE_W = 4;

  typedef logic [LAMP_W-1:0] lamp_t;

  // One-hot lamp heads {Left, Green, Yellow, Red}, plus dark for flash off-half
  localparam lamp_t LEFT_GREEN     = 4'b1000;
  localparam lamp_t STRAIGHT_GREEN = 4'b0100;
  localparam lamp_t YELLOW         = 4'b0010;
  localparam lamp_t RED            = 4'b0001;
  localparam lamp_t DARK           = 4'b0000;

  // Phase codes are visible on the phase output; keep them stable for decoders
  typedef enum logic [PHASE_W-1:0] {
    ALLRED_NS   = 4'd0,
    NS_LEFT     = 4'd1,
    NS_LEFT_YEL = 4'd2,
    NS_STR      = 4'd3,
    NS_YEL      = 4'd4,
    ALLRED_EW   = 4'd5,
    EW_LEFT     = 4'd6,
    EW_LEFT_YEL = 4'd7,
    EW_STR      = 4'd8,
    EW_YEL      = 4'd9,
    FLASH       = 4'd10
  } tl_state_e;

endpackage

// File: rtl/traffic_light_actuated_if.sv
// Sensor inputs and lamp/phase outputs between the front-end, controller and lamp drivers.
interface traffic_light_actuated_if;
  import tl_pkg::*;

  logic                ns_left_req;
  logic                ew_left_req;
  logic                ns_car;
  logic                ew_car;
  logic                flash_mode;
  lamp_t               north_tl;
  lamp_t               south_tl;
  lamp_t               east_tl;
  lamp_t               west_tl;
  logic [PHASE_W-1:0]  phase;

  // Sensor side: drives requests, observes lamps
  modport master (
    output ns_left_req, ew_left_req, ns_car, ew_car, flash_mode,
    input  north_tl, south_tl, east_tl, west_tl, phase
  );

  // Controller side
  modport slave (
    input  ns_left_req, ew_left_req, ns_car, ew_car, flash_mode,
    output north_tl, south_tl, east_tl, west_tl, phase
  );
endinterface

// File: rtl/tl_phase_timer.sv
// Phase counter: clears on request, otherwise counts up (saturating), and
// compares against a selected end value and the minimum-green threshold.
module tl_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] end_m1_i,
  input  logic [CNT_W-1:0] min_m1_i,
  output logic             done_o,
  output logic             min_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == end_m1_i);
  assign min_o  = (cnt_q >= min_m1_i);

endmodule

// File: rtl/traffic_light_actuated.sv
// Demand-actuated four-way controller: left arrows on latched demand, straight
// green between min and max length, all-red clearance, flash via all-red.
module traffic_light_actuated
  import tl_pkg::*;
#(
  parameter int unsigned LEFT_TIME    = 5,
  parameter int unsigned MIN_GREEN    = 4,
  parameter int unsigned MAX_GREEN    = 12,
  parameter int unsigned YELLOW_TIME  = 2,
  parameter int unsigned ALL_RED_TIME = 1,
  parameter int unsigned FLASH_HALF   = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_light_actuated_if.slave  bus
);

  localparam logic [CNT_W-1:0] LEFT_M1   = CNT_W'(LEFT_TIME - 1);
  localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] FLASH_M1  = CNT_W'(FLASH_HALF - 1);

  tl_state_e        state_q, state_d;
  logic             blink_q, blink_d;
  logic             ns_pend_q, ns_pend_d;
  logic             ew_pend_q, ew_pend_d;
  logic [CNT_W-1:0] end_m1;
  logic             tmr_clr;
  logic             tmr_done;
  logic             tmr_min;
  lamp_t            ns_lamp;
  lamp_t            ew_lamp;

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmr_clr),
    .end_m1_i (end_m1),
    .min_m1_i (MIN_M1),
    .done_o   (tmr_done),
    .min_o    (tmr_min)
  );

  // Duration the timer compares against in the current state
  always_comb begin
    end_m1 = ALLRED_M1;
    case (state_q)
      NS_LEFT, EW_LEFT:                     end_m1 = LEFT_M1;
      NS_LEFT_YEL, EW_LEFT_YEL,
      NS_YEL, EW_YEL:                       end_m1 = YEL_M1;
      NS_STR, EW_STR:                       end_m1 = MAX_M1;
      FLASH:                                end_m1 = FLASH_M1;
      default:                              end_m1 = ALLRED_M1;
    endcase
  end

  // Next state, timer clear, blink and demand latches
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALLRED_NS:   if (tmr_done) state_d = bus.flash_mode ? FLASH :
                                           (ns_pend_q ? NS_LEFT : NS_STR);
      NS_LEFT:     if (tmr_done) state_d = NS_LEFT_YEL;
      NS_LEFT_YEL: if (tmr_done) state_d = NS_STR;
      NS_STR:      if (tmr_done || (tmr_min && (bus.ew_car || ew_pend_q)))
                     state_d = NS_YEL;
      NS_YEL:      if (tmr_done) state_d = ALLRED_EW;
      ALLRED_EW:   if (tmr_done) state_d = bus.flash_mode ? FLASH :
                                           (ew_pend_q ? EW_LEFT : EW_STR);
      EW_LEFT:     if (tmr_done) state_d = EW_LEFT_YEL;
      EW_LEFT_YEL: if (tmr_done) state_d = EW_STR;
      EW_STR:      if (tmr_done || (tmr_min && (bus.ns_car || ns_pend_q)))
                     state_d = EW_YEL;
      EW_YEL:      if (tmr_done) state_d = ALLRED_NS;
      FLASH:       if (!bus.flash_mode) state_d = ALLRED_NS;
      default:     state_d = ALLRED_NS;
    endcase

    // Counter restarts on every state change and on each blink toggle
    tmr_clr = (state_d != state_q) || ((state_q == FLASH) && tmr_done);

    // Blink sits at 1 outside FLASH so it reads 1 on entry
    blink_d = 1'b1;
    if (state_q == FLASH) begin
      blink_d = tmr_done ? ~blink_q : blink_q;
    end

    // Demand latches: set outside the served left phase, clear on entry wins
    ns_pend_d = ns_pend_q;
    if (bus.ns_left_req && (state_q != NS_LEFT)) ns_pend_d = 1'b1;
    if ((state_d == NS_LEFT) && (state_q != NS_LEFT)) ns_pend_d = 1'b0;

    ew_pend_d = ew_pend_q;
    if (bus.ew_left_req && (state_q != EW_LEFT)) ew_pend_d = 1'b1;
    if ((state_d == EW_LEFT) && (state_q != EW_LEFT)) ew_pend_d = 1'b0;
  end

  // State, blink and demand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ALLRED_NS;
      blink_q   <= 1'b1;
      ns_pend_q <= 1'b0;
      ew_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      blink_q   <= blink_d;
      ns_pend_q <= ns_pend_d;
      ew_pend_q <= ew_pend_d;
    end
  end

  // Moore lamp decode from registered state
  always_comb begin
    ns_lamp = RED;
    ew_lamp = RED;
    case (state_q)
      NS_LEFT:     ns_lamp = LEFT_GREEN;
      NS_LEFT_YEL: ns_lamp = YELLOW;
      NS_STR:      ns_lamp = STRAIGHT_GREEN;
      NS_YEL:      ns_lamp = YELLOW;
      EW_LEFT:     ew_lamp = LEFT_GREEN;
      EW_LEFT_YEL: ew_lamp = YELLOW;
      EW_STR:      ew_lamp = STRAIGHT_GREEN;
      EW_YEL:      ew_lamp = YELLOW;
      FLASH: begin
        ns_lamp = blink_q ? YELLOW : DARK;
        ew_lamp = blink_q ? RED : DARK;
      end
      default: begin
        ns_lamp = RED;
        ew_lamp = RED;
      end
    endcase
  end

  assign bus.north_tl = ns_lamp;
  assign bus.south_tl = ns_lamp;
  assign bus.east_tl  = ew_lamp;
  assign bus.west_tl  = ew_lamp;
  assign bus.phase    = PHASE_W'(state_q);

endmodule

// File: tb/tb_traffic_light_actuated.sv
// Directed, table-driven bench for traffic_light_actuated.
module tb_traffic_light_actuated;

  localparam logic [3:0] ARN = 4'd0, NL = 4'd1, NLY = 4'd2, NS = 4'd3, NY = 4'd4;
  localparam logic [3:0] ARE = 4'd5, EL = 4'd6, ELY = 4'd7, ES = 4'd8, EY = 4'd9;
  localparam logic [3:0] FL = 4'd10;

  localparam logic [3:0] LL = 4'b1000, LG = 4'b0100, LY = 4'b0010, LR = 4'b0001, LD = 4'b0000;

  // input bits {reset, ns_left_req, ew_left_req, ns_car, ew_car, flash_mode}
  localparam logic [5:0] I_0   = 6'b000000;
  localparam logic [5:0] I_RST = 6'b100000;
  localparam logic [5:0] I_NLR = 6'b010000;
  localparam logic [5:0] I_ELR = 6'b001000;
  localparam logic [5:0] I_NC  = 6'b000100;
  localparam logic [5:0] I_EC  = 6'b000010;

  typedef struct {
    logic [5:0] in;
    logic [3:0] ph;
    int         n;
  } vec_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  traffic_light_actuated_if bus ();

  traffic_light_actuated dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] lamps(input logic [3:0] ph);
    case (ph)
      NL:      return {LL, LR};
      NLY:     return {LY, LR};
      NS:      return {LG, LR};
      NY:      return {LY, LR};
      EL:      return {LR, LL};
      ELY:     return {LR, LY};
      ES:      return {LR, LG};
      EY:      return {LR, LY};
      default: return {LR, LR};
    endcase
  endfunction

  function automatic void add(input logic [5:0] in, input logic [3:0] ph, input int n);
    vec_t v;
    v.in = in;
    v.ph = ph;
    v.n  = n;
    vq.push_back(v);
  endfunction

  task automatic chk(input string what, input int rec, input int cyc,
                     input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s rec=%0d cyc=%0d got=%b expected=%b", what, rec, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {reset, bus.ns_left_req, bus.ew_left_req, bus.ns_car, bus.ew_car, bus.flash_mode} = in;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lamps(input string tag, input int rec, input int cyc,
                           input logic [3:0] ns, input logic [3:0] ew);
    chk({tag, " north"}, rec, cyc, {4'b0, bus.north_tl}, {4'b0, ns});
    chk({tag, " south"}, rec, cyc, {4'b0, bus.south_tl}, {4'b0, ns});
    chk({tag, " east"},  rec, cyc, {4'b0, bus.east_tl},  {4'b0, ew});
    chk({tag, " west"},  rec, cyc, {4'b0, bus.west_tl},  {4'b0, ew});
  endtask

  initial begin
    logic [7:0] el;
    logic [3:0] prev;
    int         cnt;
    bit         found;

    drive(I_RST);

    // idle: 30-cycle cycle, no left phases
    add(I_RST, ARN, 1);
    add(I_0, NS, 12); add(I_0, NY, 2); add(I_0, ARE, 1);
    add(I_0, ES, 12); add(I_0, EY, 2); add(I_0, ARN, 1);
    add(I_0, NS, 12); add(I_0, NY, 1);

    // cross demand: min green 4, max green 12 when no cross demand
    add(I_RST, ARN, 1);
    add(I_EC, NS, 4); add(I_EC, NY, 2); add(I_EC, ARE, 1);
    add(I_EC, ES, 12); add(I_EC, EY, 2); add(I_EC, ARN, 1);
    add(I_EC | I_NC, NS, 4); add(I_EC | I_NC, NY, 2); add(I_EC | I_NC, ARE, 1);
    add(I_EC | I_NC, ES, 4); add(I_EC | I_NC, EY, 2);

    // ns left pulse during EW_STR: early EW exit, then NS_LEFT served once
    add(I_RST, ARN, 1);
    add(I_0, NS, 12); add(I_0, NY, 2); add(I_0, ARE, 1);
    add(I_0, ES, 1); add(I_NLR, ES, 1); add(I_0, ES, 2); add(I_0, EY, 2);
    add(I_0, ARN, 1); add(I_0, NL, 5); add(I_0, NLY, 2); add(I_0, NS, 12);
    add(I_0, NY, 2); add(I_0, ARE, 1); add(I_0, ES, 12); add(I_0, EY, 2);
    add(I_0, ARN, 1); add(I_0, NS, 1);

    // req held only through NS_LEFT: not re-latched
    add(I_RST, ARN, 1);
    add(I_NLR, NS, 1); add(I_0, NS, 11); add(I_0, NY, 2); add(I_0, ARE, 1);
    add(I_0, ES, 4); add(I_0, EY, 2); add(I_0, ARN, 1);
    add(I_NLR, NL, 5); add(I_NLR, NLY, 1); add(I_0, NLY, 1);
    add(I_0, NS, 12); add(I_0, NY, 2); add(I_0, ARE, 1); add(I_0, ES, 12);
    add(I_0, EY, 2); add(I_0, ARN, 1); add(I_0, NS, 1);

    // req held into NS_LEFT_YEL: re-latches, NS_LEFT served again
    add(I_RST, ARN, 1);
    add(I_NLR, NS, 1); add(I_0, NS, 11); add(I_0, NY, 2); add(I_0, ARE, 1);
    add(I_0, ES, 4); add(I_0, EY, 2); add(I_0, ARN, 1);
    add(I_NLR, NL, 5); add(I_NLR, NLY, 2); add(I_0, NS, 12); add(I_0, NY, 2);
    add(I_0, ARE, 1); add(I_0, ES, 4); add(I_0, EY, 2); add(I_0, ARN, 1);
    add(I_0, NL, 1);

    // full EW left sequence
    add(I_RST, ARN, 1);
    add(I_ELR, NS, 1); add(I_0, NS, 3); add(I_0, NY, 2); add(I_0, ARE, 1);
    add(I_0, EL, 5); add(I_0, ELY, 2); add(I_0, ES, 12); add(I_0, EY, 2);
    add(I_0, ARN, 1); add(I_0, NS, 1);

    // reset during EW_LEFT with ns demand pending: aborts and clears latches
    add(I_RST, ARN, 1);
    add(I_ELR, NS, 1); add(I_0, NS, 3); add(I_0, NY, 2); add(I_0, ARE, 1);
    add(I_0, EL, 1); add(I_NLR, EL, 1); add(I_RST, ARN, 1);
    add(I_0, NS, 12); add(I_0, NY, 2); add(I_0, ARE, 1); add(I_0, ES, 12);
    add(I_0, EY, 2); add(I_0, ARN, 1); add(I_0, NS, 1);

    for (int i = 0; i < vq.size(); i++) begin
      for (int c = 0; c < vq[i].n; c++) begin
        drive(vq[i].in);
        step();
        el = lamps(vq[i].ph);
        chk("phase", i, c, {4'b0, bus.phase}, {4'b0, vq[i].ph});
        chk_lamps("lamp", i, c, el[7:4], el[3:0]);
      end
    end

    // flash raised mid NS_STR: waits for ALLRED_EW, then blinks
    drive(I_RST);
    step();
    chk("flash reset phase", -1, 0, {4'b0, bus.phase}, {4'b0, ARN});
    drive(I_0);
    repeat (5) step();
    bus.flash_mode = 1'b1;
    cnt   = 0;
    found = 1'b0;
    prev  = bus.phase;
    for (int k = 0; k < 40 && !found; k++) begin
      prev = bus.phase;
      step();
      cnt++;
      if (bus.phase == FL) found = 1'b1;
    end
    chk("flash reached", -1, cnt, {7'b0, found}, 8'd1);
    chk("flash latency", -1, cnt, 8'(cnt), 8'd11);
    chk("flash prev phase", -1, cnt, {4'b0, prev}, {4'b0, ARE});
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      chk("flash phase", -1, k, {4'b0, bus.phase}, {4'b0, FL});
      if (((k / 3) % 2) == 0) chk_lamps("flash on", -1, k, LY, LR);
      else                    chk_lamps("flash off", -1, k, LD, LD);
    end
    bus.flash_mode = 1'b0;
    step();
    chk("flash exit phase", -1, 0, {4'b0, bus.phase}, {4'b0, ARN});
    chk_lamps("flash exit", -1, 0, LR, LR);
    step();
    chk("after flash phase", -1, 1, {4'b0, bus.phase}, {4'b0, NS});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_actuated.md
# traffic_light_actuated

Parametrised, demand-actuated successor to the fixed-time four-way intersection controller. It drives the same four 4-bit signal heads. Left-turn arrows are served only on latched demand, straight green runs between a minimum and maximum length depending on cross-street demand, and an all-red clearance interval separates the two axes. A maintenance flash mode is entered and left only through all-red. The block sits between the intersection sensor front-end and the lamp drivers.

## Interface
- LEFT_TIME, 5, cycles of left-arrow green
- MIN_GREEN, 4, minimum straight-green cycles
- MAX_GREEN, 12, maximum straight-green cycles
- YELLOW_TIME, 2, cycles of yellow, used after both left and straight phases
- ALL_RED_TIME, 1, cycles of all-red clearance
- FLASH_HALF, 3, cycles per half-period of the flash blink
- CNT_W, 8, phase counter width; every time parameter must be ≥1 and ≤2^CNT_W; MIN_GREEN ≤ MAX_GREEN
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- ns_left_req  in  1  north/south left-lane detector, level or pulse
- ew_left_req  in  1  east/west left-lane detector
- ns_car  in  1  north/south straight-lane presence (cross demand for EW green)
- ew_car  in  1  east/west straight-lane presence (cross demand for NS green)
- flash_mode  in  1  maintenance flash request, level
- north_tl, south_tl, east_tl, west_tl  out  4 each  lamp one-hot {Left, Green, Yellow, Red}: 1000, 0100, 0010, 0001
- phase  out  4  current state code, for debug and monitoring

## Operation
- States: ALLRED_NS, NS_LEFT, NS_LEFT_YEL, NS_STR, NS_YEL, ALLRED_EW, EW_LEFT, EW_LEFT_YEL, EW_STR, EW_YEL, FLASH.
- Cycle order: ALLRED_NS → (NS_LEFT → NS_LEFT_YEL if ns_left_pend) → NS_STR → NS_YEL → ALLRED_EW → (EW_LEFT → EW_LEFT_YEL if ew_left_pend) → EW_STR → EW_YEL → ALLRED_NS.
- Lamps:
  - The active axis shows 1000, 0010, 0100 or 0010 in its LEFT, LEFT_YEL, STR and YEL states respectively.
  - The idle axis shows 0001.
  - ALLRED states drive 0001 on all four heads.
- Demand latches:
  - ns_left_pend is set by ns_left_req in any state except NS_LEFT.
  - It is cleared on the transition into NS_LEFT.
  - Set and clear in the same cycle: clear wins.
  - EW mirrors this with ew_left_pend and EW_LEFT.
- NS_STR exit: when (counter ≥ MIN_GREEN-1 and (ew_car or ew_left_pend)), or when counter == MAX_GREEN-1. EW_STR mirrors this using ns_car and ns_left_pend.
- Flash entry:
  - flash_mode is checked only when an ALLRED state expires.
  - If flash_mode is high at that point, the next state is FLASH, not the next phase.
  - Flash requests raised mid-phase wait for the next all-red.
- FLASH lamps:
  - A blink register is set to 1 on entry and toggles every FLASH_HALF cycles.
  - north_tl and south_tl show 0010 when blink is 1, else 0000.
  - east_tl and west_tl show 0001 when blink is 1, else 0000.
- Flash exit: flash_mode low in FLASH → ALLRED_NS next cycle, counter 0.
- Reset: state ALLRED_NS, counter 0, both pend latches 0, blink 1. All outputs read 0001 and phase reads the ALLRED_NS code in the cycle after reset is sampled. Reset mid-phase aborts that phase immediately.

## Timing
- Counter: cleared on every state change, otherwise increments by 1.
- Timed states (LEFT, YEL, ALLRED): exit when counter == T-1, so each lasts exactly T cycles.
- Outputs are a combinational decode of registered state (Moore). Lamps change in the same cycle the state register updates.
- Sensor and request inputs are sampled on the clk edge. Effect latency: one cycle to a pend latch, and at most one cycle to a green-exit decision.
- Counter width: CNT_W bits with no wrap. MAX_GREEN-1 is always reached first.
- FLASH: counter restarts at each blink toggle.
- Default full cycle with no demand: 1+12+2+1+12+2 = 30 cycles.

## Structure
- Package tl_pkg holds:
  - lamp encodings LEFT_GREEN, STRAIGHT_GREEN, YELLOW, RED and DARK (0000)
  - the 11-state enum with its 4-bit codes, shared by phase decoders elsewhere.
- Sub-module tl_phase_timer: CNT_W-bit counter with a clear input and an equality/threshold compare against a selected duration. Instantiate it once; the FSM selects which duration to compare.

## Test plan
- Reset, all inputs low → ALLRED_NS for 1 cycle, NS_STR for 12, NS_YEL for 2, ALLRED_EW for 1, EW_STR for 12, EW_YEL for 2. The cycle repeats every 30 cycles and left states never appear.
- ew_car held high from reset → NS_STR lasts exactly 4 cycles. With ns_car also high, EW_STR lasts 4 cycles.
- 1-cycle ns_left_req pulse during EW_STR → the next NS phase is NS_LEFT (1000 for 5 cycles), then NS_LEFT_YEL (0010 for 2 cycles), then NS_STR. ns_left_pend reads 0 after NS_LEFT is entered.
- ns_left_req held high through NS_LEFT → not re-latched. It re-latches from NS_LEFT_YEL onward and NS_LEFT is served again next cycle.
- flash_mode raised mid-NS_STR → normal sequence continues to the end of ALLRED_EW, then FLASH.
  - NS heads alternate 0010/0000 and EW heads alternate 0001/0000, each half lasting 3 cycles.
  - flash_mode dropped → ALLRED_NS the next cycle.
- reset asserted for 1 cycle during EW_LEFT → all heads 0001 the next cycle, pend latches cleared, and the sequence restarts from ALLRED_NS.
